// File: rtl/glyph_pkg.sv
// Shared constants and state encoding for the 5x7 glyph pixel path.
package glyph_pkg;
  localparam int GLYPH_W    = 5;
  localparam int GLYPH_H    = 7;
  localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;
  localparam int GRB_W      = 24;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;
endpackage

// File: rtl/glyph_pixel_sequencer.sv
// Latches one ROM glyph per char handshake and streams it column-major as GRB pixels plus gap columns.
// First pixel one cycle after accept; each pixel waits on pix_ready; char_ready re-opens on the last pixel.
module glyph_pixel_sequencer #(
  parameter int GLYPH_W  = glyph_pkg::GLYPH_W,
  parameter int GLYPH_H  = glyph_pkg::GLYPH_H,
  parameter int GAP_COLS = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          char_valid,
  output logic                          char_ready,
  input  logic [6:0]                    char_code,
  output logic [6:0]                    rom_addr,
  input  logic [glyph_pkg::GLYPH_BITS-1:0] rom_data,
  input  logic [glyph_pkg::GRB_W-1:0]   fg_grb,
  input  logic [glyph_pkg::GRB_W-1:0]   bg_grb,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [glyph_pkg::GRB_W-1:0]   pix_grb,
  output logic [2:0]                    pix_col,
  output logic [2:0]                    pix_row,
  output logic                          pix_last
);
  import glyph_pkg::*;

  localparam logic [2:0] LAST_COL = 3'(GLYPH_W + GAP_COLS - 1);
  localparam logic [2:0] LAST_ROW = 3'(GLYPH_H - 1);

  state_e                 state_q, state_d;
  logic [GLYPH_BITS-1:0]  bitmap_q, bitmap_d;
  logic [GRB_W-1:0]       fg_q, fg_d;
  logic [GRB_W-1:0]       bg_q, bg_d;
  logic [2:0]             col_q, col_d;
  logic [2:0]             row_q, row_d;

  logic       pix_fire;
  logic       accept;
  logic       bit_set;
  logic [5:0] bit_idx;

  assign rom_addr = char_code;

  // Row 0 / col 0 lives in the MSB of the bitmap.
  always_comb begin
    bit_idx    = 6'(GLYPH_BITS - 1) - (6'(GLYPH_W) * 6'(row_q) + 6'(col_q));
    bit_set    = 1'b0;
    if (col_q < 3'(GLYPH_W)) begin
      bit_set = bitmap_q[bit_idx];
    end
    pix_valid  = (state_q == EMIT);
    pix_last   = pix_valid && (col_q == LAST_COL) && (row_q == LAST_ROW);
    pix_grb    = '0;
    if (pix_valid) begin
      pix_grb = bit_set ? fg_q : bg_q;
    end
    pix_col    = pix_valid ? col_q : 3'd0;
    pix_row    = pix_valid ? row_q : 3'd0;
    pix_fire   = pix_valid && pix_ready;
    char_ready = !rst && (!pix_valid || (pix_fire && pix_last));
    accept     = char_valid && char_ready;
  end

  always_comb begin
    state_d  = state_q;
    bitmap_d = bitmap_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    col_d    = col_q;
    row_d    = row_q;
    if (accept) begin
      state_d  = EMIT;
      bitmap_d = rom_data;
      fg_d     = fg_grb;
      bg_d     = bg_grb;
      col_d    = 3'd0;
      row_d    = 3'd0;
    end else if (pix_fire) begin
      if (pix_last) begin
        state_d = IDLE;
        col_d   = 3'd0;
        row_d   = 3'd0;
      end else if (row_q == LAST_ROW) begin
        row_d = 3'd0;
        col_d = col_q + 3'd1;
      end else begin
        row_d = row_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bitmap_q <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      col_q    <= 3'd0;
      row_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      bitmap_q <= bitmap_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end
endmodule

// File: doc/glyph_pixel_sequencer.md
# glyph_pixel_sequencer

Downstream consumer of the 5x7 character ROM: accepts one ASCII code per valid/ready handshake, drives the ROM address, latches the 35-bit glyph bitmap and emits it as a column-major stream of 24-bit GRB pixels (foreground/background colour per bit), followed by configurable blank gap columns. It sits between the text/character register interface and the WS2812B serializer, producing one pixel per downstream handshake for scrolling LED matrices.

## Interface
- GLYPH_W, default 5: glyph columns.
- GLYPH_H, default 7: glyph rows.
- GAP_COLS, default 1: blank (background) columns appended after each glyph; 0 allowed.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- char_valid  in  1  char_code valid.
- char_ready  out  1  block can accept a character this cycle.
- char_code  in  7  ASCII code.
- rom_addr  out  7  combinational copy of char_code to the ROM.
- rom_data  in  35  combinational ROM bitmap for rom_addr; codes below 32 return all ones.
- fg_grb  in  24  colour for set bits, sampled at character accept.
- bg_grb  in  24  colour for clear bits and gap columns, sampled at character accept.
- pix_valid  out  1  pixel output valid.
- pix_ready  in  1  downstream accepts pixel.
- pix_grb  out  24  pixel colour.
- pix_col  out  3  column within glyph cell (0..GLYPH_W+GAP_COLS-1).
- pix_row  out  3  row (0 = top).
- pix_last  out  1  final pixel of the current character cell.

## Operation
- Bitmap bit for (row r, col c) is rom_data[34 - (r*GLYPH_W + c)]; row 0 top, col 0 left.
- States: IDLE, EMIT. Reset -> IDLE.
- Accept = char_valid && char_ready. On accept: latch rom_data, fg_grb, bg_grb; col=0, row=0; go to EMIT.
- char_ready = (state==IDLE) || (pix_valid && pix_ready && pix_last). Allows zero-bubble back-to-back characters.
- EMIT: pix_valid=1. pix_grb = fg if col<GLYPH_W and bitmap bit set, else bg. Gap columns always bg.
- Order: rows 0..GLYPH_H-1 within a column, then next column; cell = GLYPH_H*(GLYPH_W+GAP_COLS) pixels (42 default).
- On pixel accept: row increments; at row GLYPH_H-1 row wraps to 0 and col increments. On pix_last accept: new accept in same cycle -> reload and stay EMIT; otherwise -> IDLE.
- Outputs pix_grb/pix_col/pix_row/pix_last held stable while pix_valid && !pix_ready.
- Colour inputs changing mid-character have no effect until next accept.

## Timing
- Reset values: char_ready=1 the cycle after reset is released (reset forces IDLE); pix_valid=0, pix_grb=0, pix_col=0, pix_row=0, pix_last=0. char_ready=0 while rst high.
- Accept in cycle N -> first pixel (col0,row0) valid in N+1. Latency 1.
- Each pixel consumes exactly one pix_ready cycle; with pix_ready held high a cell takes 42 cycles, back-to-back chars stream continuously.
- rst asserted mid-character: next cycle IDLE, pix_valid=0, partial character dropped, no pix_last issued.
- char_valid with char_ready=0: ignored, no latch.
- Counters width 3; col/row never exceed cell limits.

## Structure
- Shared package glyph_pkg: GLYPH_W, GLYPH_H, GLYPH_BITS (35), state enum {IDLE, EMIT}, GRB width constant (24).
- Single module, no sub-module; char_rom is instantiated alongside at the parent level and wired via rom_addr/rom_data.
- Bitmap register 35 bits, colour registers 2x24, counters row/col.

## Test plan
- Reset release, char 0x05 (ROM all ones), fg=0x00FF00, bg=0x000000, pix_ready=1 -> 35 pixels 0x00FF00 cols 0..4, then 7 pixels 0x000000 col 5, pix_last on 42nd, char_ready back high.
- Bench ROM maps 0x41 to 35'h1_2345_6789 -> each pixel matches bit 34-(r*5+c), column-major order, first pixel one cycle after accept.
- Two chars valid continuously, pix_ready=1 -> 84 consecutive valid pixels, no bubble, second accept coincides with first pix_last.
- pix_ready random 50% -> outputs stable while stalled, no pixel lost or duplicated, total 42 per char.
- rst pulsed at pixel 20 -> pix_valid 0 next cycle, no pix_last, next char restarts at col0,row0.
- GAP_COLS=0 -> 35 pixels per cell, pix_last at (col4,row6).
